// File: rtl/multi_clock_divider.sv
// NUM_CH programmable clock dividers sharing one system clock. Each channel
// produces a one-cycle tick at terminal count and a 50%-duty toggled clock.
module multi_clock_divider #(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 26,
  parameter int DEFAULT_TC = 50_000_000,
  parameter int RESET_EN   = 1,
  parameter int CH_W       = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_tc,
  input  logic              cfg_en,
  input  logic              cfg_now,
  input  logic              sync,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] div_clk,
  output logic              cfg_err
);

  localparam logic [CNT_W-1:0]  TC_RST = CNT_W'(DEFAULT_TC);
  localparam logic [NUM_CH-1:0] EN_RST = (RESET_EN != 0) ? {NUM_CH{1'b1}} : '0;

  logic [CNT_W-1:0]  cnt       [NUM_CH];
  logic [CNT_W-1:0]  active_tc [NUM_CH];
  logic [CNT_W-1:0]  pend_tc   [NUM_CH];
  logic [NUM_CH-1:0] en;
  logic [NUM_CH-1:0] hit;
  logic [NUM_CH-1:0] reload;
  logic [NUM_CH-1:0] wrap;
  logic              cfg_ok;

  assign cfg_ok = cfg_we && (32'(cfg_ch) < NUM_CH);

  // A write forces an immediate reload when it cannot be deferred to a wrap:
  // explicit cfg_now, a disabled or disabling channel, or a coincident sync.
  always_comb begin
    hit    = '0;
    reload = '0;
    wrap   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      hit[i]    = cfg_ok && (cfg_ch == CH_W'(i));
      reload[i] = hit[i] && (sync || cfg_now || !en[i] || !cfg_en);
      wrap[i]   = (cnt[i] == active_tc[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i]       <= '0;
        active_tc[i] <= TC_RST;
        pend_tc[i]   <= TC_RST;
      end
      en      <= EN_RST;
      tick    <= '0;
      div_clk <= '0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_we && !cfg_ok;
      for (int i = 0; i < NUM_CH; i++) begin
        if (hit[i]) en[i] <= cfg_en;
        if (reload[i]) begin
          cnt[i]       <= '0;
          active_tc[i] <= cfg_tc;
          pend_tc[i]   <= cfg_tc;
          tick[i]      <= 1'b0;
          if (sync && en[i]) div_clk[i] <= 1'b0;
        end else if (!en[i]) begin
          cnt[i]  <= '0;
          tick[i] <= 1'b0;
        end else if (sync) begin
          cnt[i]       <= '0;
          div_clk[i]   <= 1'b0;
          tick[i]      <= 1'b0;
          active_tc[i] <= pend_tc[i];
        end else begin
          if (hit[i]) pend_tc[i] <= cfg_tc;
          if (wrap[i]) begin
            // Deferred TC takes effect exactly on the wrap edge so the
            // period in flight finishes with its old length.
            cnt[i]       <= '0;
            tick[i]      <= 1'b1;
            div_clk[i]   <= ~div_clk[i];
            active_tc[i] <= hit[i] ? cfg_tc : pend_tc[i];
          end else begin
            cnt[i]  <= cnt[i] + CNT_W'(1);
            tick[i] <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Bench for multi_clock_divider: period-based reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_multi_clock_divider;

  localparam int NUM_CH     = 4;
  localparam int CNT_W      = 8;
  localparam int DEFAULT_TC = 4;
  localparam int CH_W       = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cfg_we = 1'b0;
  logic [CH_W-1:0]   cfg_ch = '0;
  logic [CNT_W-1:0]  cfg_tc = '0;
  logic              cfg_en = 1'b0;
  logic              cfg_now = 1'b0;
  logic              sync = 1'b0;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] div_clk;
  logic              cfg_err;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  multi_clock_divider #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_TC(DEFAULT_TC), .RESET_EN(1), .CH_W(CH_W)
  ) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_tc(cfg_tc),
    .cfg_en(cfg_en), .cfg_now(cfg_now), .sync(sync), .tick(tick),
    .div_clk(div_clk), .cfg_err(cfg_err)
  );

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: each channel is a position within a period of tc+1 clocks.
  int              m_pos  [NUM_CH];
  int              m_tc   [NUM_CH];
  int              m_pend [NUM_CH];
  bit              m_en   [NUM_CH];
  logic [NUM_CH-1:0] m_tick;
  logic [NUM_CH-1:0] m_div;
  logic            m_err;
  bit              m_ok = 0;

  always @(posedge clk) begin : model
    bit valid, hit, restarted;
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_pos[i] = 0; m_tc[i] = DEFAULT_TC; m_pend[i] = DEFAULT_TC; m_en[i] = 1;
      end
      m_tick = '0; m_div = '0; m_err = 0; m_ok = 1;
    end else begin
      valid = cfg_we && (int'(cfg_ch) < NUM_CH);
      m_err = cfg_we && !valid;
      for (int i = 0; i < NUM_CH; i++) begin
        hit = valid && (int'(cfg_ch) == i);
        restarted = 0;
        if (sync && m_en[i]) begin
          m_pos[i] = 0; m_div[i] = 0; m_tick[i] = 0; m_tc[i] = m_pend[i];
          restarted = 1;
        end
        if (hit && (restarted || cfg_now || !m_en[i] || !cfg_en)) begin
          m_tc[i] = int'(cfg_tc); m_pend[i] = int'(cfg_tc);
          m_pos[i] = 0; m_tick[i] = 0;
        end else if (!m_en[i]) begin
          m_pos[i] = 0; m_tick[i] = 0;
        end else if (!restarted) begin
          if (hit) m_pend[i] = int'(cfg_tc);
          if (m_pos[i] + 1 == m_tc[i] + 1) begin
            m_pos[i] = 0; m_tick[i] = 1; m_div[i] = ~m_div[i]; m_tc[i] = m_pend[i];
          end else begin
            m_pos[i] = m_pos[i] + 1; m_tick[i] = 0;
          end
        end
        if (hit) m_en[i] = cfg_en;
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      check("model_tick", int'(tick), int'(m_tick));
      check("model_div_clk", int'(div_clk), int'(m_div));
      check("model_cfg_err", int'(cfg_err), int'(m_err));
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input int ch, input int tc, input bit en, input bit now);
    cfg_we = 1; cfg_ch = CH_W'(ch); cfg_tc = CNT_W'(tc); cfg_en = en; cfg_now = now;
    cyc();
    cfg_we = 0;
  endtask

  initial begin
    int first, coinc;
    repeat (3) cyc();
    check("reset_tick", int'(tick), 0);
    check("reset_div", int'(div_clk), 0);
    check("reset_err", int'(cfg_err), 0);
    reset = 0;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      check("first_ticks", int'(tick), (k == 5 || k == 10) ? 'hF : 0);
      check("first_div", int'(div_clk), (k >= 5 && k < 10) ? 'hF : 0);
    end

    wr(1, 3, 1, 0);
    wr(2, 3, 1, 1);
    check("ch2_now_no_tick", int'(tick[2]), 0);
    check("ch1_deferred_mid", int'(tick[1]), 0);
    for (int j = 1; j <= 11; j++) begin
      cyc();
      check("ch1_deferred", int'(tick[1]), (j == 3 || j == 7 || j == 11) ? 1 : 0);
      check("ch2_now", int'(tick[2]), (j == 4 || j == 8) ? 1 : 0);
    end

    wr(0, 1, 1, 1);
    wr(1, 2, 1, 1);
    wr(2, 4, 1, 1);
    wr(3, 4, 0, 1);
    sync = 1;
    cyc();
    sync = 0;
    check("sync_div", int'(div_clk[2:0]), 0);
    check("sync_tick", int'(tick), 0);
    first = 0; coinc = 0;
    for (int j = 1; j <= 60; j++) begin
      cyc();
      if (tick[2:0] == 3'b111) begin
        coinc++;
        if (first == 0) first = j;
      end
    end
    check("lcm_first", first, 30);
    check("lcm_count", coinc, 2);

    wr(0, 1, 0, 0);
    for (int j = 0; j <= 5; j++) begin
      check("disabled_tick", int'(tick[0]), 0);
      cyc();
    end
    wr(0, 2, 1, 0);
    for (int j = 1; j <= 3; j++) begin
      cyc();
      check("reenable_tick", int'(tick[0]), (j == 3) ? 1 : 0);
    end
    wr(5, 1, 1, 1);
    check("cfg_err_pulse", int'(cfg_err), 1);
    cyc();
    check("cfg_err_clear", int'(cfg_err), 0);

    sync = 1;
    wr(1, 5, 1, 0);
    sync = 0;
    check("sync_wr_tick", int'(tick[1]), 0);
    for (int j = 1; j <= 6; j++) begin
      cyc();
      check("sync_wr_period", int'(tick[1]), (j == 6) ? 1 : 0);
    end

    repeat (3) cyc();
    reset = 1;
    #1;
    check("async_reset_tick", int'(tick), 0);
    check("async_reset_div", int'(div_clk), 0);
    check("async_reset_err", int'(cfg_err), 0);
    repeat (2) cyc();
    reset = 0;

    for (int n = 0; n < 3000; n++) begin
      reset   = ($urandom_range(0, 199) == 0);
      cfg_we  = ($urandom_range(0, 4) == 0);
      cfg_ch  = CH_W'($urandom_range(0, 7));
      cfg_tc  = CNT_W'($urandom_range(0, 6));
      cfg_en  = ($urandom_range(0, 4) != 0);
      cfg_now = $urandom_range(0, 1) == 1;
      sync    = ($urandom_range(0, 29) == 0);
      cyc();
    end
    reset = 0; cfg_we = 0; sync = 0;
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
